// File: rtl/encryptor_lcu_ctrl.sv
// AES-128 encryptor logic control unit: key schedule then per-block round sequencing.
// Optional macro ENCRYPTOR_LCU_REKEY_EN: key_received in IDLE reruns the key schedule.
module encryptor_lcu_ctrl (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       key_received,
  input  logic       data_ready,
  input  logic       fifo_full,
  output logic       data_load,
  output logic       data_taken,
  output logic       data_out_load,
  output logic       data_reg_input,
  output logic [1:0] process_output,
  output logic       ark_enable,
  output logic       sb_enable,
  output logic       mc_enable,
  output logic       sr_enable,
  output logic       key_gen_enable,
  output logic [3:0] iter_in,
  output logic [3:0] iter_out,
  output logic       key_reg_load
);

  typedef enum logic [3:0] {
    KEY_WAIT       = 4'd0,
    LOAD_FIRST_KEY = 4'd1,
    ENABLE_KEY_GEN = 4'd2,
    LOAD_KEY       = 4'd3,
    LAST_ENABLE    = 4'd4,
    LOAD_LAST_KEY  = 4'd5,
    IDLE           = 4'd6,
    LOAD_DATA      = 4'd7,
    ARK_1          = 4'd8,
    SB_2           = 4'd9,
    SR_2           = 4'd10,
    MC_2           = 4'd11,
    ARK_2          = 4'd12,
    SB_3           = 4'd13,
    SR_3           = 4'd14,
    ARK_3          = 4'd15
  } state_t;

  localparam logic [1:0] PO_ARK = 2'b00;
  localparam logic [1:0] PO_SB  = 2'b01;
  localparam logic [1:0] PO_SR  = 2'b11;
  localparam logic [1:0] PO_MC  = 2'b10;

  state_t     state;
  state_t     state_next;
  logic [3:0] r;
  logic [3:0] r_next;

  // State and round counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= KEY_WAIT;
      r     <= 4'd0;
    end else begin
      state <= state_next;
      r     <= r_next;
    end
  end

  // Next state and next round index
  always_comb begin
    state_next = state;
    r_next     = r;
    unique case (state)
      KEY_WAIT: begin
        if (key_received)
          state_next = LOAD_FIRST_KEY;
      end
      LOAD_FIRST_KEY: begin
        state_next = ENABLE_KEY_GEN;
        r_next     = 4'd1;
      end
      ENABLE_KEY_GEN: state_next = LOAD_KEY;
      LOAD_KEY: begin
        if (r == 4'd9) begin
          state_next = LAST_ENABLE;
          r_next     = 4'd10;
        end else begin
          state_next = ENABLE_KEY_GEN;
          r_next     = r + 4'd1;
        end
      end
      LAST_ENABLE: state_next = LOAD_LAST_KEY;
      LOAD_LAST_KEY: begin
        state_next = IDLE;
        r_next     = 4'd0;
      end
      IDLE: begin
`ifdef ENCRYPTOR_LCU_REKEY_EN
        if (key_received)
          state_next = LOAD_FIRST_KEY;
        else if (data_ready && !fifo_full)
          state_next = LOAD_DATA;
`else
        if (data_ready && !fifo_full)
          state_next = LOAD_DATA;
`endif
      end
      LOAD_DATA: begin
        state_next = ARK_1;
        r_next     = 4'd0;
      end
      ARK_1: begin
        state_next = SB_2;
        r_next     = r + 4'd1;
      end
      SB_2: state_next = SR_2;
      SR_2: state_next = MC_2;
      MC_2: state_next = ARK_2;
      ARK_2: begin
        if (r == 4'd9) begin
          state_next = SB_3;
          r_next     = 4'd10;
        end else begin
          state_next = SB_2;
          r_next     = r + 4'd1;
        end
      end
      SB_3: state_next = SR_3;
      SR_3: state_next = ARK_3;
      ARK_3: begin
        state_next = IDLE;
        r_next     = 4'd0;
      end
    endcase
  end

  // Moore output decode from state and round index
  always_comb begin
    data_load      = 1'b0;
    data_taken     = 1'b0;
    data_out_load  = 1'b0;
    data_reg_input = 1'b0;
    process_output = PO_ARK;
    ark_enable     = 1'b0;
    sb_enable      = 1'b0;
    mc_enable      = 1'b0;
    sr_enable      = 1'b0;
    key_gen_enable = 1'b0;
    iter_in        = 4'd0;
    iter_out       = 4'd0;
    key_reg_load   = 1'b0;
    unique case (state)
      KEY_WAIT, IDLE: ;
      LOAD_FIRST_KEY: key_reg_load = 1'b1;
      ENABLE_KEY_GEN, LAST_ENABLE: begin
        key_gen_enable = 1'b1;
        iter_in        = r;
        iter_out       = r - 4'd1;
      end
      LOAD_KEY, LOAD_LAST_KEY: begin
        key_gen_enable = 1'b1;
        key_reg_load   = 1'b1;
        iter_in        = r;
        iter_out       = r - 4'd1;
      end
      LOAD_DATA: begin
        data_load  = 1'b1;
        data_taken = 1'b1;
      end
      ARK_1, ARK_2: begin
        data_load      = 1'b1;
        data_reg_input = 1'b1;
        ark_enable     = 1'b1;
        process_output = PO_ARK;
        iter_out       = r;
      end
      SB_2, SB_3: begin
        data_load      = 1'b1;
        data_reg_input = 1'b1;
        sb_enable      = 1'b1;
        process_output = PO_SB;
        iter_out       = r;
      end
      SR_2, SR_3: begin
        data_load      = 1'b1;
        data_reg_input = 1'b1;
        sr_enable      = 1'b1;
        process_output = PO_SR;
        iter_out       = r;
      end
      MC_2: begin
        data_load      = 1'b1;
        data_reg_input = 1'b1;
        mc_enable      = 1'b1;
        process_output = PO_MC;
        iter_out       = r;
      end
      ARK_3: begin
        data_out_load  = 1'b1;
        data_reg_input = 1'b1;
        ark_enable     = 1'b1;
        process_output = PO_ARK;
        iter_out       = r;
      end
    endcase
  end

endmodule

// File: tb/tb_encryptor_lcu_ctrl.sv
// Directed bench for encryptor_lcu_ctrl: key schedule, blocks, fifo gating, reset.
// Every output is compared each cycle against hand-built expected vectors.
module tb_encryptor_lcu_ctrl;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       key_received;
  logic       data_ready;
  logic       fifo_full;
  logic       data_load;
  logic       data_taken;
  logic       data_out_load;
  logic       data_reg_input;
  logic [1:0] process_output;
  logic       ark_enable;
  logic       sb_enable;
  logic       mc_enable;
  logic       sr_enable;
  logic       key_gen_enable;
  logic [3:0] iter_in;
  logic [3:0] iter_out;
  logic       key_reg_load;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  encryptor_lcu_ctrl dut (
    .clk(clk),
    .n_rst(n_rst),
    .key_received(key_received),
    .data_ready(data_ready),
    .fifo_full(fifo_full),
    .data_load(data_load),
    .data_taken(data_taken),
    .data_out_load(data_out_load),
    .data_reg_input(data_reg_input),
    .process_output(process_output),
    .ark_enable(ark_enable),
    .sb_enable(sb_enable),
    .mc_enable(mc_enable),
    .sr_enable(sr_enable),
    .key_gen_enable(key_gen_enable),
    .iter_in(iter_in),
    .iter_out(iter_out),
    .key_reg_load(key_reg_load)
  );

  // {dl,dt,dol,dri,po[1:0],ark,sb,mc,sr,kg,ii[3:0],io[3:0],krl}
  wire [19:0] obs = {data_load, data_taken, data_out_load,
                     data_reg_input, process_output, ark_enable,
                     sb_enable, mc_enable, sr_enable, key_gen_enable,
                     iter_in, iter_out, key_reg_load};

  localparam logic [19:0] V_ZERO = 20'h0;

  function automatic logic [19:0] v_key(input logic kg,
                                        input logic krl,
                                        input logic [3:0] ii,
                                        input logic [3:0] io);
    return {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0,
            1'b0, 1'b0, 1'b0, kg, ii, io, krl};
  endfunction

  // op: 0 ARK, 1 SB, 2 SR, 3 MC, 4 final ARK, 5 LOAD_DATA
  function automatic logic [19:0] v_enc(input int op,
                                        input logic [3:0] io);
    case (op)
      0: return {4'b1001, 2'b00, 5'b10000, 4'd0, io, 1'b0};
      1: return {4'b1001, 2'b01, 5'b01000, 4'd0, io, 1'b0};
      2: return {4'b1001, 2'b11, 5'b00010, 4'd0, io, 1'b0};
      3: return {4'b1001, 2'b10, 5'b00100, 4'd0, io, 1'b0};
      4: return {4'b0011, 2'b00, 5'b10000, 4'd0, io, 1'b0};
      default: return {4'b1100, 2'b00, 5'b00000, 4'd0, 4'd0, 1'b0};
    endcase
  endfunction

  task automatic check(input string tag, input logic [19:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called with the DUT just entered LOAD_FIRST_KEY
  task automatic run_keys();
    check("load_first_key", v_key(1'b0, 1'b1, 4'd0, 4'd0));
    for (int i = 1; i <= 9; i++) begin
      step();
      check($sformatf("ekg_%0d", i),
            v_key(1'b1, 1'b0, 4'(i), 4'(i - 1)));
      step();
      check($sformatf("load_key_%0d", i),
            v_key(1'b1, 1'b1, 4'(i), 4'(i - 1)));
    end
    step();
    check("last_enable", v_key(1'b1, 1'b0, 4'd10, 4'd9));
    step();
    check("load_last_key", v_key(1'b1, 1'b1, 4'd10, 4'd9));
    step();
    check("key_idle", V_ZERO);
  endtask

  // Called with the DUT just entered LOAD_DATA; ends in IDLE
  task automatic run_block(input string nm);
    check({nm, "_load_data"}, v_enc(5, 4'd0));
    data_ready = 1'b0;
    step();
    check({nm, "_ark1"}, v_enc(0, 4'd0));
    for (int k = 1; k <= 9; k++) begin
      step();
      check($sformatf("%s_sb_%0d", nm, k), v_enc(1, 4'(k)));
      step();
      check($sformatf("%s_sr_%0d", nm, k), v_enc(2, 4'(k)));
      step();
      check($sformatf("%s_mc_%0d", nm, k), v_enc(3, 4'(k)));
      step();
      check($sformatf("%s_ark_%0d", nm, k), v_enc(0, 4'(k)));
    end
    step();
    check({nm, "_sb3"}, v_enc(1, 4'd10));
    step();
    check({nm, "_sr3"}, v_enc(2, 4'd10));
    step();
    check({nm, "_ark3"}, v_enc(4, 4'd10));
    step();
    check({nm, "_idle"}, V_ZERO);
  endtask

  initial begin
    n_rst = 1'b0;
    key_received = 1'b0;
    data_ready = 1'b0;
    fifo_full = 1'b0;
    #12;
    check("in_reset", V_ZERO);
    step();
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("key_wait_%0d", i), V_ZERO);
    end

    key_received = 1'b1;
    step();
    key_received = 1'b0;
    data_ready = 1'b1;
    run_keys();

    step();
    run_block("blk1");

`ifdef ENCRYPTOR_LCU_REKEY_EN
    key_received = 1'b1;
    step();
    key_received = 1'b0;
    run_keys();
`else
    key_received = 1'b1;
    step();
    key_received = 1'b0;
    check("idle_key_ignored", V_ZERO);
`endif

    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("gap_idle_%0d", i), V_ZERO);
    end
    data_ready = 1'b1;
    step();
    fifo_full = 1'b1;
    run_block("blk2");

    data_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fifo_hold_%0d", i), V_ZERO);
    end
    fifo_full = 1'b0;
    step();
    check("blk3_load_data", v_enc(5, 4'd0));
    data_ready = 1'b0;
    step();
    check("blk3_ark1", v_enc(0, 4'd0));
    step();
    check("blk3_sb_1", v_enc(1, 4'd1));
    step();
    check("blk3_sr_1", v_enc(2, 4'd1));
    step();
    check("blk3_mc_1", v_enc(3, 4'd1));
    n_rst = 1'b0;
    #1;
    check("reset_in_mc", V_ZERO);
    step();
    n_rst = 1'b1;
    data_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_wait_%0d", i), V_ZERO);
    end
    data_ready = 1'b0;
    key_received = 1'b1;
    step();
    key_received = 1'b0;
    run_keys();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
